// File: rtl/bcd_to_bin_pkg.sv
// Shared types and helpers for the sequential BCD-to-binary decoder.
// Holds the FSM state encoding, the largest legal digit and the output width check.
package bcd_to_bin_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } bcd_state_e;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;

  // Number of bits needed to hold 10^digits - 1, evaluated at elaboration.
  function automatic int bcd_min_width(input int digits);
    longint unsigned max_val;
    int              w;
    max_val = 64'd1;
    for (int i = 0; i < digits; i++) begin
      max_val = max_val * 64'd10;
    end
    max_val = max_val - 64'd1;
    w = 0;
    for (int b = 0; b < 64; b++) begin
      if ((max_val >> b) != 64'd0) begin
        w = b + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/bcd_mac10.sv
// One decimal accumulate step: acc_out = acc_in*10 + digit, truncated to WIDTH.
// err_out flags a nibble outside 0..9; the raw nibble value is still added.
module bcd_mac10
  import bcd_to_bin_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [WIDTH-1:0] acc_out,
  output logic             err_out
);

  logic [WIDTH-1:0] times8;
  logic [WIDTH-1:0] times2;
  logic [WIDTH-1:0] digit_ext;

  // Shift-and-add keeps the multiply-by-10 to two adders with no multiplier.
  assign times8    = acc_in << 3;
  assign times2    = acc_in << 1;
  assign digit_ext = WIDTH'(digit);
  assign acc_out   = times8 + times2 + digit_ext;
  assign err_out   = (digit > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_to_bin.sv
// Sequential BCD-to-binary decoder: one digit per clock, most significant first,
// with valid/ready handshakes on input and output.
module bcd_to_bin
  import bcd_to_bin_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int WIDTH  = 10
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*DIGITS-1:0]   in_bcd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_bin,
  output logic                  out_err
);

  localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  generate
    if (DIGITS < 1) begin : g_digits_check
      $error("bcd_to_bin: DIGITS must be at least 1");
    end
    if (WIDTH < bcd_min_width(DIGITS)) begin : g_width_check
      $error("bcd_to_bin: WIDTH too small to hold 10^DIGITS-1");
    end
  endgenerate

  bcd_state_e            state_reg;
  logic [WIDTH-1:0]      acc_reg;
  logic [CNT_W-1:0]      cnt_reg;
  logic [4*DIGITS-1:0]   sreg_reg;
  logic                  err_reg;
  logic                  in_ready_reg;
  logic                  out_valid_reg;
  logic [WIDTH-1:0]      out_bin_reg;
  logic                  out_err_reg;

  logic [WIDTH-1:0]      acc_next;
  logic                  digit_err;

  bcd_mac10 #(
    .WIDTH(WIDTH)
  ) u_mac10 (
    .acc_in (acc_reg),
    .digit  (sreg_reg[4*DIGITS-1 -: 4]),
    .acc_out(acc_next),
    .err_out(digit_err)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      sreg_reg      <= '0;
      err_reg       <= 1'b0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      out_bin_reg   <= '0;
      out_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            sreg_reg     <= in_bcd;
            acc_reg      <= '0;
            err_reg      <= 1'b0;
            cnt_reg      <= CNT_W'(DIGITS - 1);
            in_ready_reg <= 1'b0;
            state_reg    <= CONV;
          end
        end
        CONV: begin
          acc_reg  <= acc_next;
          err_reg  <= err_reg | digit_err;
          sreg_reg <= sreg_reg << 4;
          cnt_reg  <= cnt_reg - 1'b1;
          // Last digit: publish the result straight from the step logic.
          if (cnt_reg == '0) begin
            out_bin_reg   <= acc_next;
            out_err_reg   <= err_reg | digit_err;
            out_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: begin
          out_valid_reg <= 1'b0;
          in_ready_reg  <= 1'b1;
          state_reg     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_bin   = out_bin_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_bcd_to_bin.sv
// Directed self-checking bench for bcd_to_bin (default 3-digit build plus a 1-digit build).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_bcd_to_bin;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;

  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_bcd;
  logic        out_valid;
  logic        out_ready;
  logic [9:0]  out_bin;
  logic        out_err;

  logic        s_in_valid;
  logic        s_in_ready;
  logic [3:0]  s_in_bcd;
  logic        s_out_valid;
  logic        s_out_ready;
  logic [3:0]  s_out_bin;
  logic        s_out_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bcd_to_bin dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_bcd   (in_bcd),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_bin  (out_bin),
    .out_err  (out_err)
  );

  bcd_to_bin #(
    .DIGITS(1),
    .WIDTH (4)
  ) dut1 (
    .clk      (clk),
    .reset_n  (reset_n),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_bcd   (s_in_bcd),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_bin  (s_out_bin),
    .out_err  (s_out_err)
  );

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Called on the falling edge after the accept edge; returns falling edges until out_valid, or -1.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!out_valid) lat = -1;
  endtask

  // One full transaction with out_ready high; starts and ends on a falling edge in IDLE.
  task automatic convert(input logic [11:0] bcd, output logic [9:0] bin, output logic err,
                         output int lat);
    in_bcd    = bcd;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    bin = out_bin;
    err = out_err;
    $display("tx bcd=%03h bin=%0d err=%0d lat=%0d", bcd, bin, err, lat);
    @(negedge clk);
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_bcd = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_bcd = '0; s_out_ready = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_bin !== 10'd0) begin errors++; $display("FAIL reset_out_bin: got %0d expected 0", out_bin); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL reset_out_err: got %b expected 0", out_err); end
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL reset_s_out_valid: got %b expected 0", s_out_valid); end
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (s_in_ready !== 1'b1) begin errors++; $display("FAIL reset_s_in_ready: got %b expected 1", s_in_ready); end
    $display("tx reset released");
  endtask

  task automatic test_basic();
    int lat;
    in_bcd = 12'h255; in_valid = 1'b1; out_ready = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_in_ready_idle: got %b expected 1", in_ready); end
    @(negedge clk);
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL basic_in_ready_conv: got %b expected 0", in_ready); end
    wait_out(lat);
    $display("tx bcd=255 bin=%0d err=%0d lat=%0d", out_bin, out_err, lat);
    checks++; if (lat !== 3) begin errors++; $display("FAIL basic_latency: got %0d expected 3", lat); end
    checks++; if (out_bin !== 10'd255) begin errors++; $display("FAIL basic_bin: got %0d expected 255", out_bin); end
    checks++; if (out_err !== 1'b0) begin errors++; $display("FAIL basic_err: got %b expected 0", out_err); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL basic_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    int lat;
    in_bcd = 12'h999; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_bcd = 12'h000;
    wait_out(lat);
    $display("tx bcd=999 bin=%0d err=%0d lat=%0d", out_bin, out_err, lat);
    checks++; if (lat !== 3 || out_bin !== 10'd999) begin errors++; $display("FAIL b2b_first: got bin=%0d lat=%0d expected bin=999 lat=3", out_bin, lat); end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL b2b_gap: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
    @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL b2b_second_accept: got ready=%b expected 0", in_ready); end
    in_valid = 1'b0;
    wait_out(lat);
    $display("tx bcd=000 bin=%0d err=%0d lat=%0d", out_bin, out_err, lat);
    checks++; if (lat !== 3 || out_bin !== 10'd0 || out_err !== 1'b0) begin errors++; $display("FAIL b2b_second: got bin=%0d err=%b lat=%0d expected bin=0 err=0 lat=3", out_bin, out_err, lat); end
    @(negedge clk);
  endtask

  task automatic test_invalid_digit();
    logic [9:0] bin;
    logic       err;
    int         lat;
    convert(12'h1A5, bin, err, lat);
    checks++; if (bin !== 10'd205 || err !== 1'b1 || lat !== 3) begin errors++; $display("FAIL invalid_1A5: got bin=%0d err=%b lat=%0d expected bin=205 err=1 lat=3", bin, err, lat); end
    convert(12'h042, bin, err, lat);
    checks++; if (bin !== 10'd42 || err !== 1'b0) begin errors++; $display("FAIL err_clears_042: got bin=%0d err=%b expected bin=42 err=0", bin, err); end
  endtask

  task automatic test_backpressure();
    int lat;
    in_bcd = 12'h128; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    wait_out(lat);
    checks++; if (lat !== 3 || out_bin !== 10'd128) begin errors++; $display("FAIL bp_result: got bin=%0d lat=%0d expected bin=128 lat=3", out_bin, lat); end
    in_valid = 1'b1; in_bcd = 12'h999;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_bin !== 10'd128 || out_err !== 1'b0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got valid=%b bin=%0d err=%b ready=%b expected valid=1 bin=128 err=0 ready=0",
                 c, out_valid, out_bin, out_err, in_ready);
      end
    end
    $display("tx bcd=128 bin=%0d held 10 cycles", out_bin);
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_conv();
    logic [9:0] bin;
    logic       err;
    int         lat;
    int         stray;
    in_bcd = 12'h777; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_bin !== 10'd0 || out_err !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_outputs: got valid=%b bin=%0d err=%b ready=%b expected valid=0 bin=0 err=0 ready=1",
               out_valid, out_bin, out_err, in_ready);
    end
    stray = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++; if (stray !== 0) begin errors++; $display("FAIL midreset_no_valid: got %0d stray cycles expected 0", stray); end
    $display("tx bcd=777 discarded by reset");
    convert(12'h321, bin, err, lat);
    checks++; if (bin !== 10'd321 || err !== 1'b0 || lat !== 3) begin errors++; $display("FAIL after_reset_321: got bin=%0d err=%b lat=%0d expected bin=321 err=0 lat=3", bin, err, lat); end
  endtask

  task automatic test_single_digit();
    s_in_bcd = 4'h7; s_in_valid = 1'b1; s_out_ready = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    checks++; if (s_out_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b expected 0", s_out_valid); end
    @(negedge clk);
    $display("tx d1 bcd=7 bin=%0d err=%0d", s_out_bin, s_out_err);
    checks++; if (s_out_valid !== 1'b1 || s_out_bin !== 4'd7 || s_out_err !== 1'b0) begin errors++; $display("FAIL single_7: got valid=%b bin=%0d err=%b expected valid=1 bin=7 err=0", s_out_valid, s_out_bin, s_out_err); end
    @(negedge clk);
    s_in_bcd = 4'hB; s_in_valid = 1'b1;
    @(negedge clk);
    s_in_valid = 1'b0;
    @(negedge clk);
    $display("tx d1 bcd=B bin=%0d err=%0d", s_out_bin, s_out_err);
    checks++; if (s_out_valid !== 1'b1 || s_out_bin !== 4'd11 || s_out_err !== 1'b1) begin errors++; $display("FAIL single_B: got valid=%b bin=%0d err=%b expected valid=1 bin=11 err=1", s_out_valid, s_out_bin, s_out_err); end
    @(negedge clk);
  endtask

  task automatic test_sweep();
    logic [9:0] bin;
    logic       err;
    int         lat;
    for (int v = 0; v < 256; v++) begin
      convert(to_bcd(v), bin, err, lat);
      checks++;
      if (bin !== 10'(v) || err !== 1'b0 || lat !== 3) begin
        errors++;
        $display("FAIL sweep_%0d: got bin=%0d err=%b lat=%0d expected bin=%0d err=0 lat=3", v, bin, err, lat, v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_invalid_digit();
    test_backpressure();
    test_reset_mid_conv();
    test_single_digit();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
